// File: rtl/wav_frame_reader.sv
// wav_frame_reader: streams overlapping frames of samples out of a sample BRAM.
// Optional pre-emphasis filter is built only when WAV_READER_PREEMPH_EN is defined.
module wav_frame_reader #(
  parameter int DWIDTH    = 30,
  parameter int AWIDTH    = 9,
  parameter int WORDS     = 400,
  parameter int FRAME_LEN = 200,
  parameter int HOP       = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] bram_addr,
  output logic              bram_write,
  input  logic [DWIDTH-1:0] bram_rdata,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic [7:0]        frame_idx
);

  localparam int NF    = (WORDS - FRAME_LEN) / HOP + 1;
  localparam int DEPTH = 4;

  localparam logic [AWIDTH-1:0] LAST_OFF = AWIDTH'(FRAME_LEN - 1);
  localparam logic [AWIDTH-1:0] HOP_A    = AWIDTH'(HOP);
  localparam logic [AWIDTH-1:0] ONE_A    = AWIDTH'(1);
  localparam logic [7:0]        LAST_F   = 8'(NF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] fstart_q, fstart_d;
  logic [AWIDTH-1:0] off_q, off_d;
  logic [7:0]        fcnt_q, fcnt_d;

  logic [AWIDTH-1:0] bram_addr_q;
  logic              av_q, a_first_q, a_last_q;
  logic [7:0]        a_fidx_q;
  logic              dv_q, d_first_q, d_last_q;
  logic [7:0]        d_fidx_q;

  logic [DWIDTH-1:0] b_data_q [DEPTH];
  logic              b_first_q [DEPTH];
  logic              b_last_q [DEPTH];
  logic [7:0]        b_fidx_q [DEPTH];
  logic [1:0]        wr_q, rd_q;
  logic [2:0]        cnt_q;

  logic              vld, pop, can_go, credit_ok, issue;
  logic              at_lo, at_lf, issue_last;
  logic [3:0]        occ;
  logic [DWIDTH-1:0] push_data;

  assign vld        = (cnt_q != 3'd0);
  assign pop        = vld && out_ready;
  // Data already buffered or in flight must fit once this read lands.
  assign occ        = {1'b0, cnt_q} + {3'b0, av_q} + {3'b0, dv_q};
  assign credit_ok  = occ < (4'(DEPTH) + {3'b0, pop});
  assign can_go     = (state_q == S_RUN) ||
                      ((state_q == S_IDLE) && start);
  assign issue      = can_go && credit_ok;
  assign at_lo      = (off_q == LAST_OFF);
  assign at_lf      = (fcnt_q == LAST_F);
  assign issue_last = issue && at_lo && at_lf;

  assign bram_addr  = bram_addr_q;
  assign bram_write = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = issue_last ? S_DRAIN : S_RUN;
      S_RUN:   if (issue_last) state_d = S_DRAIN;
      S_DRAIN: if (!av_q && !dv_q && !vld) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_RUN, S_DRAIN: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default:        ;
    endcase
  end

  // Address generator: ascending within a frame, jump to next frame start.
  always_comb begin
    addr_d   = addr_q;
    fstart_d = fstart_q;
    off_d    = off_q;
    fcnt_d   = fcnt_q;
    if (state_q == S_DONE) begin
      addr_d   = '0;
      fstart_d = '0;
      off_d    = '0;
      fcnt_d   = '0;
    end else if (issue) begin
      if (at_lo) begin
        fstart_d = fstart_q + HOP_A;
        addr_d   = fstart_q + HOP_A;
        off_d    = '0;
        fcnt_d   = fcnt_q + 8'd1;
      end else begin
        addr_d = addr_q + ONE_A;
        off_d  = off_q + ONE_A;
      end
    end
  end

  // Address generator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      fstart_q <= '0;
      off_q    <= '0;
      fcnt_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      fstart_q <= fstart_d;
      off_q    <= off_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Read pipeline: address stage, then data-valid stage with frame tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_addr_q <= '0;
      av_q        <= 1'b0;
      a_first_q   <= 1'b0;
      a_last_q    <= 1'b0;
      a_fidx_q    <= '0;
      dv_q        <= 1'b0;
      d_first_q   <= 1'b0;
      d_last_q    <= 1'b0;
      d_fidx_q    <= '0;
    end else begin
      av_q <= issue;
      if (issue) begin
        bram_addr_q <= addr_q;
        a_first_q   <= (off_q == '0);
        a_last_q    <= at_lo;
        a_fidx_q    <= fcnt_q;
      end
      dv_q      <= av_q;
      d_first_q <= a_first_q;
      d_last_q  <= a_last_q;
      d_fidx_q  <= a_fidx_q;
    end
  end

`ifdef WAV_READER_PREEMPH_EN
  localparam logic signed [DWIDTH+1:0] Y_MAX =
    {3'b000, {(DWIDTH-1){1'b1}}};
  localparam logic signed [DWIDTH+1:0] Y_MIN =
    {3'b111, {(DWIDTH-1){1'b0}}};

  logic [DWIDTH-1:0]        hist_q;
  logic signed [DWIDTH+1:0] x_e, h_e, y_e;

  // y = x - h + h/32 with history cleared at each frame start, saturated.
  always_comb begin
    x_e = {{2{bram_rdata[DWIDTH-1]}}, bram_rdata};
    h_e = d_first_q ? '0 : {{2{hist_q[DWIDTH-1]}}, hist_q};
    y_e = x_e - h_e + (h_e >>> 5);
    if (y_e > Y_MAX)      push_data = Y_MAX[DWIDTH-1:0];
    else if (y_e < Y_MIN) push_data = Y_MIN[DWIDTH-1:0];
    else                  push_data = y_e[DWIDTH-1:0];
  end

  // History holds the previous raw sample entering the buffer.
  always_ff @(posedge clk) begin
    if (rst)       hist_q <= '0;
    else if (dv_q) hist_q <= bram_rdata;
  end
`else
  assign push_data = bram_rdata;
`endif

  // Skid buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (dv_q) wr_q <= wr_q + 2'd1;
      if (pop)  rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_q + {2'b0, dv_q} - {2'b0, pop};
    end
  end

  // Skid buffer storage; content is only observed while counted valid.
  always_ff @(posedge clk) begin
    if (dv_q) begin
      b_data_q[wr_q]  <= push_data;
      b_first_q[wr_q] <= d_first_q;
      b_last_q[wr_q]  <= d_last_q;
      b_fidx_q[wr_q]  <= d_fidx_q;
    end
  end

  assign out_valid = vld;
  assign out_data  = vld ? b_data_q[rd_q] : '0;
  assign out_first = vld && b_first_q[rd_q];
  assign out_last  = vld && b_last_q[rd_q];
  assign frame_idx = vld ? b_fidx_q[rd_q] : 8'd0;

endmodule

// File: tb/tb_wav_frame_reader.sv
// tb_wav_frame_reader: directed checks of frame order, handshake, abort and restart.
// Pre-emphasis vectors run only when WAV_READER_PREEMPH_EN is defined.
module tb_wav_frame_reader;

  localparam int DW    = 30;
  localparam int AW    = 9;
  localparam int FL    = 200;
  localparam int HOP   = 80;
  localparam int TOTAL = 600;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, bram_write;
  logic          out_valid, out_ready, out_first, out_last;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata, out_data;
  logic [7:0]    frame_idx;
  logic [DW-1:0] mem [512];

  int errors = 0;
  int checks = 0;

  wav_frame_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bram_addr  (bram_addr),
    .bram_write (bram_write),
    .bram_rdata (bram_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_first  (out_first),
    .out_last   (out_last),
    .frame_idx  (frame_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bram_rdata <= mem[bram_addr];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [DW-1:0] d,
                                       input logic f,
                                       input logic l,
                                       input logic [7:0] i);
    return {24'b0, d, f, l, i};
  endfunction

  function automatic logic [63:0] exp_pack(input int k);
    int f, o, a;
    logic [DW-1:0] d;
`ifdef WAV_READER_PREEMPH_EN
    longint x, h, y;
    longint maxv, minv;
`endif
    f = k / FL;
    o = k % FL;
    a = f * HOP + o;
`ifdef WAV_READER_PREEMPH_EN
    maxv = (64'sd1 <<< (DW - 1)) - 1;
    minv = -(64'sd1 <<< (DW - 1));
    x = longint'($signed(mem[a]));
    h = (o == 0) ? 64'sd0 : longint'($signed(mem[a-1]));
    y = x - h + (h >>> 5);
    if (y > maxv) y = maxv;
    if (y < minv) y = minv;
    d = y[DW-1:0];
`else
    d = mem[a];
`endif
    return pack(d, o == 0, o == FL - 1, 8'(f));
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 512; i++) begin
      case (mode)
        0: mem[i] = DW'(i);
        1: mem[i] = DW'(1000);
        default: mem[i] = (i % 2 == 0) ? 30'h1FFF_FFFF : 30'h2000_0000;
      endcase
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_pass(input string name, input int pct,
                          input int stop_at, input bit poke);
    int k, cyc, dones, bubbles, first_v, max_a, d2;
    bit seen, stall, fin;
    k = 0; cyc = 0; dones = 0; bubbles = 0; first_v = 9999;
    max_a = 0; seen = 0; stall = 0; fin = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 6000 && !fin) begin
      out_ready = ($urandom_range(99) < pct);
      start = poke && (cyc == 50);
      if (cyc == 0) check({name, "_busy0"}, busy, 1);
      if (int'(bram_addr) > max_a) max_a = int'(bram_addr);
      if (stall) check({name, "_hold"}, out_valid, 1);
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          first_v = cyc;
        end
        if (k < TOTAL)
          check($sformatf("%s_x%0d", name, k),
                pack(out_data, out_first, out_last, frame_idx),
                exp_pack(k));
      end else if (seen && k < TOTAL) begin
        bubbles++;
      end
      stall = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        k++;
        if (stop_at != 0 && k == stop_at) fin = 1;
      end
      if (done) begin
        dones++;
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (stop_at != 0) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check({name, "_rst_valid"}, out_valid, 0);
      check({name, "_rst_busy"}, busy, 0);
      rst = 1'b0;
      d2 = dones;
      repeat (20) begin
        @(posedge clk); #1;
        if (done) d2++;
      end
      check({name, "_nodone"}, d2, 0);
      check({name, "_count"}, k, stop_at);
    end else begin
      check({name, "_count"}, k, TOTAL);
      check({name, "_dones"}, dones, 1);
      check({name, "_maxaddr"}, max_a, 359);
      if (pct == 100) begin
        check({name, "_bubbles"}, bubbles, 0);
        check({name, "_latency"}, first_v <= 3, 1);
      end
      @(posedge clk); #1;
      check({name, "_idle_busy"}, busy, 0);
      check({name, "_idle_done"}, done, 0);
      check({name, "_idle_valid"}, out_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_first", out_first, 0);
    check("rst_last", out_last, 0);
    check("rst_fidx", frame_idx, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_write", bram_write, 0);

    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    check("rststart_busy", busy, 0);
    @(posedge clk); #1;
    check("rststart_busy2", busy, 0);
    check("rststart_valid", out_valid, 0);

    run_pass("full", 100, 0, 0);
    run_pass("rand", 30, 0, 0);
    run_pass("abort", 100, 150, 0);
    run_pass("replay", 100, 0, 0);
    run_pass("poke", 100, 0, 1);
    check("write_low", bram_write, 0);

`ifdef WAV_READER_PREEMPH_EN
    fill(1);
    run_pass("pe_const", 100, 0, 0);
    fill(2);
    run_pass("pe_sat", 30, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wav_frame_reader.md
WAV_FRAME_READER -- requirements
Module: wav_frame_reader

Interface
REQ-001 Parameter DWIDTH, default 30: signed sample width, matching the sample BRAM word.
REQ-002 Parameter AWIDTH, default 9: sample BRAM address width.
REQ-003 Parameter WORDS, default 400: number of valid samples stored in the BRAM.
REQ-004 Parameter FRAME_LEN, default 200: samples per frame.
REQ-005 Parameter HOP, default 80: sample offset between consecutive frame starts.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse that begins a pass over all frames.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse after the last sample of the last frame is accepted.
REQ-011 bram_addr  output  AWIDTH  read address to the sample BRAM.
REQ-012 bram_write  output  1  held constant 0, so the reader never writes.
REQ-013 bram_rdata  input  DWIDTH  signed BRAM data, valid one cycle after bram_addr.
REQ-014 out_data  output  DWIDTH  signed sample stream.
REQ-015 out_valid  output  1  out_data holds a valid sample.
REQ-016 out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-017 out_first / out_last  output  1 each  qualify the first and last sample of a frame, valid with out_valid.
REQ-018 frame_idx  output  8  zero-based index of the frame containing out_data.

Function
REQ-019 Frame count NF = floor((WORDS-FRAME_LEN)/HOP)+1, which is 3 with the defaults.
REQ-020 Frame f carries samples at addresses f*HOP through f*HOP+FRAME_LEN-1, in ascending order; overlapping samples are re-read, not cached.
REQ-021 State machine:
- IDLE goes to RUN on start.
- RUN goes to DRAIN when the last address of the last frame has been issued.
- DRAIN goes to DONE when the read pipeline and output are empty.
- DONE goes to IDLE after one cycle; done is high during DONE.
REQ-022 start is ignored outside IDLE.
REQ-023 Read latency is 1 cycle (bram_addr to bram_rdata). The block holds a skid buffer of at least 2 entries. A read is issued only if the buffer will have room for its data.
REQ-024 No sample is dropped, duplicated or reordered under any out_ready pattern.
REQ-025 out_data, out_first, out_last and frame_idx stay stable while out_valid is high and out_ready is low.
REQ-026 Throughput: with out_ready held high, the first out_valid occurs no later than 3 cycles after start. One sample then transfers per cycle, with no bubbles across frame boundaries.
REQ-027 The frame address counter wraps from frame start plus FRAME_LEN-1 to the next frame start. No address at or above WORDS is ever issued.
REQ-028 start coinciding with rst: rst wins.

Reset
REQ-029 On rst the block goes to IDLE on the next edge.
REQ-030 Reset values are out_valid=0, busy=0, done=0, out_first=0, out_last=0, frame_idx=0, bram_addr=0, out_data=0, skid buffer empty, pre-emphasis history 0.
REQ-031 rst mid-pass aborts the pass, produces no done pulse, and discards buffered samples.

Configuration
REQ-032 Macro WAV_READER_PREEMPH_EN.
- When defined, out_data is y[n] = x[n] - x[n-1] + (x[n-1]>>>5), an arithmetic shift giving a coefficient of 31/32. The history is 0 at each frame's first sample.
- Intermediate arithmetic is DWIDTH+2 bits, saturated to the signed DWIDTH range.
- When undefined, out_data equals the raw BRAM sample and no pre-emphasis logic is present.
- Latency and handshake are identical in both builds.

Verification
REQ-033 BRAM model mem[i]=i, defaults, out_ready=1, start pulse:
- 600 transfers, with frame 0 = 0..199, frame 1 = 80..279, frame 2 = 160..359.
- out_first/out_last exactly at frame edges.
- done exactly once, with no bubble after the first valid.
REQ-034 Same setup with out_ready random at 30% high: sequence identical to REQ-033 and out_data stable while stalled.
REQ-035 rst asserted after the 150th transfer:
- out_valid=0 and busy=0 next cycle, with no done pulse.
- A new start replays from address 0.
REQ-036 start pulsed again while busy: ignored, transfer count still 600.
REQ-037 With WAV_READER_PREEMPH_EN and mem[i]=1000 for all i:
- First sample of each frame = 1000.
- Subsequent samples = 1000-1000+31 = 31.
- With mem alternating +2^29-1 and -2^29, outputs saturate to 2^29-1 and -2^29.
